// File: rtl/load_cell_a2d_pkg.sv
// Shared types, channel map and SPI divider landmarks for the rider-sensor A2D path.
package load_cell_a2d_pkg;

    localparam int SCLK_DIV_W = 5;

    localparam logic [2:0] CH_LFT   = 3'd0;
    localparam logic [2:0] CH_RGHT  = 3'd4;
    localparam logic [2:0] CH_STEER = 3'd5;
    localparam logic [2:0] CH_BATT  = 3'd6;

    localparam logic [4:0]  DIV_FRONT    = 5'b10111;
    localparam logic [4:0]  DIV_SMPL     = 5'b01111;
    localparam logic [4:0]  DIV_SHFT     = 5'b11111;
    localparam logic [15:0] RX_DATA_MASK = 16'h0FFF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        GAP  = 3'd2,
        RD   = 3'd3,
        UPD  = 3'd4
    } slot_state_e;

    function automatic logic [2:0] rr_chan(input logic [1:0] idx);
        case (idx)
            2'd0:    rr_chan = CH_LFT;
            2'd1:    rr_chan = CH_RGHT;
            2'd2:    rr_chan = CH_STEER;
            default: rr_chan = CH_BATT;
        endcase
    endfunction

    function automatic logic [15:0] build_cmd(input logic [2:0] ch);
        build_cmd = {2'b00, ch, 11'h000};
    endfunction

endpackage

// File: rtl/load_cell_a2d_if.sv
// Sensor-path bundle: nxt request, four readings with their strobe, and the A2D SPI pins.
interface load_cell_a2d_if;
    logic        nxt;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] steer_pot;
    logic [11:0] batt;
    logic        cnv_vld;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    modport master (
        input  nxt,
        input  MISO,
        output lft_ld,
        output rght_ld,
        output steer_pot,
        output batt,
        output cnv_vld,
        output SS_n,
        output SCLK,
        output MOSI
    );

    modport slave (
        output nxt,
        output MISO,
        input  lft_ld,
        input  rght_ld,
        input  steer_pot,
        input  batt,
        input  cnv_vld,
        input  SS_n,
        input  SCLK,
        input  MOSI
    );
endinterface

// File: rtl/load_cell_a2d_spi_mstr16.sv
// 16-bit mode-3 SPI master: one frame per wrt, SCLK taken straight from the divider MSB.
module spi_mstr16
    import load_cell_a2d_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    logic                  r_busy;
    logic [SCLK_DIV_W-1:0] r_div;
    logic [4:0]            r_bit_cnt;
    logic [15:0]           r_shft;
    logic                  r_miso_smpl;
    logic                  r_ss_n;
    logic                  r_done;

    // Frame sequencer; shifting waits for the first sample, so the opening SCLK fall moves nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_div       <= DIV_SHFT;
            r_bit_cnt   <= 5'd0;
            r_shft      <= 16'h0000;
            r_miso_smpl <= 1'b0;
            r_ss_n      <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (wrt) begin
                    r_busy    <= 1'b1;
                    r_div     <= DIV_FRONT;
                    r_bit_cnt <= 5'd0;
                    r_shft    <= cmd;
                    r_ss_n    <= 1'b0;
                end
            end else begin
                r_div <= r_div + 5'd1;
                if (r_div == DIV_SMPL) begin
                    r_miso_smpl <= MISO;
                    r_bit_cnt   <= r_bit_cnt + 5'd1;
                end
                if (r_div == DIV_SHFT) begin
                    if (r_bit_cnt != 5'd0) begin
                        r_shft <= {r_shft[14:0], r_miso_smpl};
                    end
                    // Back porch ends here; park the divider so SCLK idles high.
                    if (r_bit_cnt == 5'd16) begin
                        r_busy <= 1'b0;
                        r_ss_n <= 1'b1;
                        r_done <= 1'b1;
                        r_div  <= DIV_SHFT;
                    end
                end
            end
        end
    end

    assign done    = r_done;
    assign rd_data = r_shft;
    assign SS_n    = r_ss_n;
    assign SCLK    = r_div[SCLK_DIV_W-1];
    assign MOSI    = r_shft[15];

endmodule

// File: rtl/load_cell_a2d.sv
// Round-robin A2D sampler: each slot is a command frame plus a read frame, then one reading updates.
module load_cell_a2d
    import load_cell_a2d_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    load_cell_a2d_if.master       bus
);

    slot_state_e r_state;
    logic [1:0]  r_rr;
    logic        r_wrt;
    logic        r_cnv_vld;
    logic [11:0] r_lft;
    logic [11:0] r_rght;
    logic [11:0] r_steer;
    logic [11:0] r_batt;

    logic        w_done;
    logic [15:0] w_rd_data;
    logic [15:0] w_cmd;
    logic [11:0] w_conv;
    logic        w_ss_n;
    logic        w_sclk;
    logic        w_mosi;

    assign w_cmd  = build_cmd(rr_chan(r_rr));
    assign w_conv = 12'(w_rd_data & RX_DATA_MASK);

    spi_mstr16 u_spi (
        .clk     (clk),
        .rst     (rst),
        .wrt     (r_wrt),
        .cmd     (w_cmd),
        .done    (w_done),
        .rd_data (w_rd_data),
        .SS_n    (w_ss_n),
        .SCLK    (w_sclk),
        .MOSI    (w_mosi),
        .MISO    (bus.MISO)
    );

    // Slot FSM; nxt is only looked at in IDLE, so requests during a slot are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rr      <= 2'd0;
            r_wrt     <= 1'b0;
            r_cnv_vld <= 1'b0;
            r_lft     <= 12'h000;
            r_rght    <= 12'h000;
            r_steer   <= 12'h000;
            r_batt    <= 12'h000;
        end else begin
            r_wrt     <= 1'b0;
            r_cnv_vld <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.nxt) begin
                        r_wrt   <= 1'b1;
                        r_state <= CMD;
                    end
                end
                CMD: begin
                    if (w_done) r_state <= GAP;
                end
                GAP: begin
                    r_wrt   <= 1'b1;
                    r_state <= RD;
                end
                RD: begin
                    if (w_done) r_state <= UPD;
                end
                UPD: begin
                    case (r_rr)
                        2'd0:    r_lft   <= w_conv;
                        2'd1:    r_rght  <= w_conv;
                        2'd2:    r_steer <= w_conv;
                        default: r_batt  <= w_conv;
                    endcase
                    r_cnv_vld <= 1'b1;
                    r_rr      <= r_rr + 2'd1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.lft_ld    = r_lft;
    assign bus.rght_ld   = r_rght;
    assign bus.steer_pot = r_steer;
    assign bus.batt      = r_batt;
    assign bus.cnv_vld   = r_cnv_vld;
    assign bus.SS_n      = w_ss_n;
    assign bus.SCLK      = w_sclk;
    assign bus.MOSI      = w_mosi;

endmodule

// File: tb/tb_load_cell_a2d.sv
// Scoreboard bench for load_cell_a2d with a behavioural ADC128S-style A2D on the SPI pins.
module tb_load_cell_a2d;

    typedef struct {
        int          idx;
        logic [11:0] val;
    } cnv_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    load_cell_a2d_if bus();

    load_cell_a2d u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    cnv_t        exp_cnv[$];
    logic [15:0] exp_mosi[$];
    logic [11:0] shadow[4] = '{12'h000, 12'h000, 12'h000, 12'h000};
    logic [15:0] tbl[8]    = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                               16'h0000, 16'h0000, 16'h0000, 16'h0000};
    cnv_t        mon_e;

    int n_vec      = 0;
    int n_err      = 0;
    int sclk_edges = 0;
    int ssn_falls  = 0;
    int cnv_cnt    = 0;
    int nbits      = 0;
    int tidx       = 0;
    time last_rise = 0;
    time sclk_per  = 0;
    logic [15:0] rxw     = 16'h0000;
    logic [15:0] txw     = 16'h0000;
    logic [15:0] next_tx = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // A2D model: conversion returned in a frame is for the channel addressed in the previous frame.
    always @(negedge bus.SS_n) begin
        nbits     = 0;
        tidx      = 15;
        txw       = next_tx;
        last_rise = 0;
        ssn_falls++;
    end

    always @(negedge bus.SCLK) begin
        if (bus.SS_n === 1'b0 && tidx >= 0) begin
            bus.MISO = txw[tidx];
            tidx--;
        end
    end

    always @(posedge bus.SCLK) begin
        if (bus.SS_n === 1'b0) begin
            rxw = {rxw[14:0], bus.MOSI};
            nbits++;
            if (last_rise != 0) sclk_per = $time - last_rise;
            last_rise = $time;
        end
    end

    always @(posedge bus.SS_n) begin
        if (nbits == 16) begin
            next_tx = tbl[rxw[13:11]];
            if (exp_mosi.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_frame: got MOSI 0x%0h, expected no frame", rxw);
            end else begin
                chk("mosi_word", {16'h0000, rxw}, {16'h0000, exp_mosi.pop_front()});
            end
        end
        nbits = 0;
    end

    always @(bus.SCLK) sclk_edges++;

    // Output monitor: every cnv_vld must match the next expected update, others must hold.
    always @(negedge clk) begin
        if (bus.cnv_vld === 1'b1) begin
            cnv_cnt++;
            if (exp_cnv.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_cnv_vld: got pulse, expected none");
            end else begin
                mon_e = exp_cnv.pop_front();
                shadow[mon_e.idx] = mon_e.val;
                chk("lft_ld",    {20'h0, bus.lft_ld},    {20'h0, shadow[0]});
                chk("rght_ld",   {20'h0, bus.rght_ld},   {20'h0, shadow[1]});
                chk("steer_pot", {20'h0, bus.steer_pot}, {20'h0, shadow[2]});
                chk("batt",      {20'h0, bus.batt},      {20'h0, shadow[3]});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_nxt();
        bus.nxt = 1'b1;
        @(negedge clk);
        bus.nxt = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) shadow[i] = 12'h000;
        exp_cnv.delete();
        exp_mosi.delete();
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (exp_cnv.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_slot_done"}, exp_cnv.size(), 32'd0);
        tick(4);
        chk({name, "_mosi_left"}, exp_mosi.size(), 32'd0);
    endtask

    task automatic slot(input string name, input int idx, input logic [11:0] val,
                        input logic [15:0] cmd);
        cnv_t e;
        e.idx = idx;
        e.val = val;
        exp_cnv.push_back(e);
        exp_mosi.push_back(cmd);
        exp_mosi.push_back(cmd);
        pulse_nxt();
        wait_done(name, 3000);
    endtask

    int c0;
    int f0;
    int k5;

    initial begin
        bus.nxt = 1'b0;

        // 1: reset state and a quiet idle bus
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("rst_lft",   {20'h0, bus.lft_ld},    32'h0);
        chk("rst_rght",  {20'h0, bus.rght_ld},   32'h0);
        chk("rst_steer", {20'h0, bus.steer_pot}, 32'h0);
        chk("rst_batt",  {20'h0, bus.batt},      32'h0);
        chk("rst_cnv",   {31'h0, bus.cnv_vld},   32'h0);
        chk("rst_ss_n",  {31'h0, bus.SS_n},      32'h1);
        chk("rst_sclk",  {31'h0, bus.SCLK},      32'h1);
        chk("rst_mosi",  {31'h0, bus.MOSI},      32'h0);
        sclk_edges = 0;
        tick(2000);
        chk("idle_sclk_edges", sclk_edges, 32'd0);
        chk("idle_ss_falls",   ssn_falls,  32'd0);
        chk("idle_ss_n",       {31'h0, bus.SS_n}, 32'h1);

        // 2: single left-cell conversion
        tbl[0] = 16'h03A5;
        slot("t2", 0, 12'h3A5, 16'h0000);
        chk("t2_cnv_count", cnv_cnt, 32'd1);

        // 3: full round robin plus wrap
        do_reset();
        tbl[0] = 16'h0123;
        tbl[4] = 16'h0456;
        tbl[5] = 16'h0789;
        tbl[6] = 16'h0ABC;
        c0 = cnv_cnt;
        slot("t3_lft",   0, 12'h123, 16'h0000);
        slot("t3_rght",  1, 12'h456, 16'h2000);
        slot("t3_steer", 2, 12'h789, 16'h2800);
        slot("t3_batt",  3, 12'hABC, 16'h3000);
        slot("t3_wrap",  0, 12'h123, 16'h0000);
        chk("t3_cnv_count", cnv_cnt - c0, 32'd5);

        // 4: extra nxt pulses during a slot are dropped
        c0 = cnv_cnt;
        f0 = ssn_falls;
        mon_e.idx = 1;
        mon_e.val = 12'h456;
        exp_cnv.push_back(mon_e);
        exp_mosi.push_back(16'h2000);
        exp_mosi.push_back(16'h2000);
        pulse_nxt();
        tick(100);
        pulse_nxt();
        tick(430);
        pulse_nxt();
        tick(400);
        pulse_nxt();
        wait_done("t4", 3000);
        tick(1500);
        chk("t4_cnv_count", cnv_cnt - c0,   32'd1);
        chk("t4_ss_falls",  ssn_falls - f0, 32'd2);

        // 5: reset in the middle of the read frame
        f0 = ssn_falls;
        exp_mosi.push_back(16'h2800);
        pulse_nxt();
        k5 = 0;
        while (ssn_falls - f0 < 2 && k5 < 2000) begin
            @(negedge clk);
            k5++;
        end
        chk("t5_rd_started", ssn_falls - f0, 32'd2);
        tick(260);
        #2 rst = 1'b1;
        #1;
        chk("t5_abort_ss_n",  {31'h0, bus.SS_n},      32'h1);
        chk("t5_abort_sclk",  {31'h0, bus.SCLK},      32'h1);
        chk("t5_abort_lft",   {20'h0, bus.lft_ld},    32'h0);
        chk("t5_abort_rght",  {20'h0, bus.rght_ld},   32'h0);
        chk("t5_abort_steer", {20'h0, bus.steer_pot}, 32'h0);
        chk("t5_abort_batt",  {20'h0, bus.batt},      32'h0);
        chk("t5_abort_cnv",   {31'h0, bus.cnv_vld},   32'h0);
        chk("t5_cmd_checked", exp_mosi.size(), 32'd0);
        do_reset();
        tick(2);
        slot("t5_after", 0, 12'h123, 16'h0000);

        // 6: upper nibble of the read word dropped, SCLK period
        do_reset();
        tbl[0]   = 16'hF7FF;
        sclk_per = 0;
        slot("t6", 0, 12'h7FF, 16'h0000);
        chk("t6_sclk_period", 32'(sclk_per), 32'd320);

        tick(10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
